detector_scheduler: RTL and testbench

DETECTOR_SCHEDULER -- requirements
Module: detector_scheduler

---
 rtl/detector_scheduler_if.sv | 50 +++++
 rtl/detector_scheduler.sv | 178 +++++++++++++++++
 tb/tb_detector_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/detector_scheduler_if.sv
// ---------------------------------------------------------------------------
// detector_scheduler_if
// Groups the request/data inputs and the detector-facing outputs of the
// detector scheduler into one bundle.
//
// Signals:
//   req         : level requests, bit i belongs to requester i
//   data0/data1 : pattern words of requesters 0 and 1
//   y           : sequence-detector output, one cycle behind x
//   grant       : one-hot, one-cycle acknowledge to the served requester
//   x           : serial bit driven to the detector
//   det_rst     : detector reset
//   busy        : scheduler is not idle
//   done        : one-cycle job-complete strobe
//   done_id     : requester of the last completed job
//   match_count : match count of the last completed job
//
// Modports:
//   master : the requester/detector side (drives req, data, y)
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface detector_scheduler_if #(
   parameter int WIDTH = 8
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [1:0]       req;
   logic [WIDTH-1:0] data0;
   logic [WIDTH-1:0] data1;
   logic [1:0]       y;
   logic [1:0]       grant;
   logic             x;
   logic             det_rst;
   logic             busy;
   logic             done;
   logic             done_id;
   logic [CW-1:0]    match_count;

   modport master (
      output req, data0, data1, y,
      input  grant, x, det_rst, busy, done, done_id, match_count
   );

   modport slave (
      input  req, data0, data1, y,
      output grant, x, det_rst, busy, done, done_id, match_count
   );

endinterface

// File: rtl/detector_scheduler.sv
// ---------------------------------------------------------------------------
// detector_scheduler
// Round-robin scheduler that serves two requesters. For each granted job it
// resets an external sequence detector, shifts the winner's latched pattern
// word into it MSB first, counts how many detector outputs equal MATCH_CODE,
// and reports the count and the requester id with a one-cycle done strobe.
//
// Parameters:
//   WIDTH      : serial bits per job
//   MATCH_CODE : detector output value counted as a match
//
// Ports:
//   clk : single clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   bus : detector_scheduler_if slave modport (req, data0, data1, y in;
//         grant, x, det_rst, busy, done, done_id, match_count out)
// ---------------------------------------------------------------------------
module detector_scheduler #(
   parameter int         WIDTH      = 8,
   parameter logic [1:0] MATCH_CODE = 2'b01
) (
   input logic                 clk,
   input logic                 rst,
   detector_scheduler_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      DRAIN,
      DONE
   } state_t;

   state_t           r_state;
   state_t           w_nextState;

   logic             r_lastServed;
   logic             r_winner;
   logic [WIDTH-1:0] r_shift;
   logic [BW-1:0]    r_bitCnt;
   logic [CW-1:0]    r_matchCnt;
   logic [CW-1:0]    r_matchCount;
   logic             r_doneId;

   logic             w_winner;
   logic             w_lastBit;
   logic             w_countUp;
   logic [CW-1:0]    w_countNext;
   logic [1:0]       w_grant;
   logic             w_x;
   logic             w_detRst;
   logic             w_busy;
   logic             w_done;

   // On a tie the requester that was not served last wins; a lone request
   // always wins because the other bit is zero.
   always_comb begin
      w_winner = bus.req[1];
      if (bus.req == 2'b11) begin
         w_winner = ~r_lastServed;
      end
   end

   // The detector output in SHIFT cycle 0 still reflects the reset detector,
   // so only SHIFT cycles 1..WIDTH-1 and the DRAIN cycle are scored. The
   // saturation guard keeps the count from ever wrapping past WIDTH.
   always_comb begin
      w_lastBit   = (r_bitCnt == BW'(WIDTH - 1));
      w_countUp   = 1'b0;
      if (((r_state == SHIFT) && (r_bitCnt != '0)) || (r_state == DRAIN)) begin
         w_countUp = (bus.y == MATCH_CODE) && (r_matchCnt != CW'(WIDTH));
      end
      w_countNext = w_countUp ? (r_matchCnt + CW'(1)) : r_matchCnt;
   end

   // State register; reset drops straight back to IDLE, aborting any job.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and Moore outputs. det_rst also follows rst directly so the
   // detector is held in reset for as long as the scheduler is.
   always_comb begin
      w_nextState = r_state;
      w_grant     = 2'b00;
      w_x         = 1'b0;
      w_detRst    = rst;
      w_busy      = (r_state != IDLE);
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.req != 2'b00) begin
               w_nextState = LOAD;
            end
         end
         LOAD: begin
            w_grant     = r_winner ? 2'b10 : 2'b01;
            w_detRst    = 1'b1;
            w_nextState = SHIFT;
         end
         SHIFT: begin
            w_x = r_shift[WIDTH-1];
            if (w_lastBit) begin
               w_nextState = DRAIN;
            end
         end
         DRAIN: begin
            w_nextState = DONE;
         end
         DONE: begin
            w_done      = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Job datapath: the winner's word is captured on the IDLE->LOAD edge so
   // later data changes cannot disturb the job. Results are loaded on the
   // DRAIN->DONE edge so they are already visible while done is high, and
   // they hold until the next job completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lastServed <= 1'b1;
         r_winner     <= 1'b0;
         r_shift      <= '0;
         r_bitCnt     <= '0;
         r_matchCnt   <= '0;
         r_matchCount <= '0;
         r_doneId     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req != 2'b00) begin
                  r_winner     <= w_winner;
                  r_lastServed <= w_winner;
                  r_shift      <= w_winner ? bus.data1 : bus.data0;
               end
            end
            LOAD: begin
               r_bitCnt   <= '0;
               r_matchCnt <= '0;
            end
            SHIFT: begin
               r_shift    <= r_shift << 1;
               r_bitCnt   <= r_bitCnt + BW'(1);
               r_matchCnt <= w_countNext;
            end
            DRAIN: begin
               r_matchCnt   <= w_countNext;
               r_matchCount <= w_countNext;
               r_doneId     <= r_winner;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.grant       = w_grant;
   assign bus.x           = w_x;
   assign bus.det_rst     = w_detRst;
   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.done_id     = r_doneId;
   assign bus.match_count = r_matchCount;

endmodule

// File: tb/tb_detector_scheduler.sv
// ---------------------------------------------------------------------------
// tb_detector_scheduler
// Directed bench for detector_scheduler (WIDTH=8, MATCH_CODE=2'b01).
// Inputs are driven 1 ns after the rising edge and outputs are sampled at
// the same point, so every check sees the state entered on that edge.
// ---------------------------------------------------------------------------
module tb_detector_scheduler;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   detector_scheduler_if #(.WIDTH(8)) bus ();

   detector_scheduler #(
      .WIDTH(8),
      .MATCH_CODE(2'b01)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the requester/detector side of the bus
   task automatic applyStimulus(input logic [1:0] req, input logic [7:0] d0,
                                input logic [7:0] d1, input logic [1:0] y);
      bus.req   = req;
      bus.data0 = d0;
      bus.data1 = d1;
      bus.y     = y;
   endtask

   // Outputs while reset is held, and once it is released
   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(2'b00, 8'h00, 8'h00, 2'b00);
      #3;
      compared++;
      if ({bus.grant, bus.x, bus.done, bus.done_id, bus.match_count, bus.busy} !== 10'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got grant=%b x=%b done=%b id=%b cnt=%0d busy=%b expected all 0",
                  bus.grant, bus.x, bus.done, bus.done_id, bus.match_count, bus.busy);
      end
      compared++;
      if (bus.det_rst !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reset_det_rst: got %b expected 1", bus.det_rst);
      end
      tick();
      tick();
      rst = 1'b0;
      #1;
      compared++;
      if (bus.det_rst !== 1'b0 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_release: got det_rst=%b busy=%b expected 0 0", bus.det_rst, bus.busy);
      end
   endtask

   // Requester 0 alone, A5, detector always matching
   task automatic test_single();
      logic [7:0] pattern;
      pattern = 8'hA5;
      applyStimulus(2'b01, 8'hA5, 8'h00, 2'b01);
      tick();
      compared++;
      if (bus.grant !== 2'b01 || bus.det_rst !== 1'b1 || bus.busy !== 1'b1 || bus.x !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL single_load: got grant=%b det_rst=%b busy=%b x=%b expected 01 1 1 0",
                  bus.grant, bus.det_rst, bus.busy, bus.x);
      end
      bus.req = 2'b00;
      for (int k = 0; k < 8; k++) begin
         tick();
         compared++;
         if (bus.x !== pattern[7-k] || bus.grant !== 2'b00 || bus.det_rst !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_shift%0d: got x=%b grant=%b det_rst=%b expected x=%b grant=00 det_rst=0",
                     k, bus.x, bus.grant, bus.det_rst, pattern[7-k]);
         end
      end
      tick();
      compared++;
      if (bus.x !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL single_drain: got x=%b done=%b busy=%b expected 0 0 1", bus.x, bus.done, bus.busy);
      end
      tick();
      compared++;
      if (bus.done !== 1'b1 || bus.match_count !== 4'd8 || bus.done_id !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL single_done: got done=%b cnt=%0d id=%b expected 1 8 0",
                  bus.done, bus.match_count, bus.done_id);
      end
      tick();
      compared++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.match_count !== 4'd8) begin
         mismatched++;
         $display("[TB] FAIL single_idle: got done=%b busy=%b cnt=%0d expected 0 0 8",
                  bus.done, bus.busy, bus.match_count);
      end
   endtask

   // Detector never reports the match code
   task automatic test_no_match();
      applyStimulus(2'b01, 8'hFF, 8'h00, 2'b10);
      tick();
      bus.req = 2'b00;
      for (int k = 0; k < 10; k++) begin
         tick();
      end
      compared++;
      if (bus.done !== 1'b1 || bus.match_count !== 4'd0) begin
         mismatched++;
         $display("[TB] FAIL no_match_done: got done=%b cnt=%0d expected 1 0", bus.done, bus.match_count);
      end
      tick();
   endtask

   // data0 changes mid-shift; the stream must follow the latched word
   task automatic test_data_hold();
      logic [7:0] pattern;
      pattern = 8'h96;
      applyStimulus(2'b01, 8'h96, 8'h00, 2'b01);
      tick();
      bus.req = 2'b00;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 3) begin
            bus.data0 = 8'h69;
         end
         compared++;
         if (bus.x !== pattern[7-k]) begin
            mismatched++;
            $display("[TB] FAIL data_hold_shift%0d: got x=%b expected %b", k, bus.x, pattern[7-k]);
         end
      end
      tick();
      tick();
      tick();
   endtask

   // Reset in SHIFT cycle 4 aborts the job with no done
   task automatic test_abort_reset();
      applyStimulus(2'b01, 8'hFF, 8'h00, 2'b01);
      tick();
      bus.req = 2'b00;
      for (int k = 0; k < 5; k++) begin
         tick();
      end
      compared++;
      if (bus.x !== 1'b1 || bus.busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL abort_pre: got x=%b busy=%b expected 1 1", bus.x, bus.busy);
      end
      rst = 1'b1;
      #1;
      compared++;
      if (bus.busy !== 1'b0 || bus.x !== 1'b0 || bus.det_rst !== 1'b1 || bus.done !== 1'b0
          || bus.match_count !== 4'd0) begin
         mismatched++;
         $display("[TB] FAIL abort_reset: got busy=%b x=%b det_rst=%b done=%b cnt=%0d expected 0 0 1 0 0",
                  bus.busy, bus.x, bus.det_rst, bus.done, bus.match_count);
      end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         compared++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.match_count !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL abort_after%0d: got done=%b busy=%b cnt=%0d expected 0 0 0",
                     k, bus.done, bus.busy, bus.match_count);
         end
      end
   endtask

   // Tie from reset: requester 0 first, requester 1 after one IDLE cycle
   task automatic test_back_to_back();
      logic [7:0] pattern;
      pattern = 8'h0F;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(2'b11, 8'hA5, 8'h0F, 2'b01);
      tick();
      compared++;
      if (bus.grant !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL rr_first_grant: got %b expected 01", bus.grant);
      end
      bus.req = 2'b10;
      for (int k = 0; k < 10; k++) begin
         tick();
      end
      compared++;
      if (bus.done !== 1'b1 || bus.done_id !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rr_first_done: got done=%b id=%b expected 1 0", bus.done, bus.done_id);
      end
      tick();
      compared++;
      if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL rr_idle_gap: got busy=%b grant=%b expected 0 00", bus.busy, bus.grant);
      end
      tick();
      compared++;
      if (bus.grant !== 2'b10) begin
         mismatched++;
         $display("[TB] FAIL rr_second_grant: got %b expected 10", bus.grant);
      end
      bus.req = 2'b00;
      for (int k = 0; k < 8; k++) begin
         tick();
         compared++;
         if (bus.x !== pattern[7-k]) begin
            mismatched++;
            $display("[TB] FAIL rr_second_shift%0d: got x=%b expected %b", k, bus.x, pattern[7-k]);
         end
      end
      tick();
      tick();
      compared++;
      if (bus.done !== 1'b1 || bus.done_id !== 1'b1 || bus.match_count !== 4'd8) begin
         mismatched++;
         $display("[TB] FAIL rr_second_done: got done=%b id=%b cnt=%0d expected 1 1 8",
                  bus.done, bus.done_id, bus.match_count);
      end
      tick();
   endtask

   // Request raised while busy waits, then wins after the job's IDLE cycle
   task automatic test_busy_request();
      applyStimulus(2'b01, 8'h5A, 8'hC3, 2'b01);
      tick();
      compared++;
      if (bus.grant !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL busy_first_grant: got %b expected 01", bus.grant);
      end
      bus.req = 2'b00;
      tick();
      tick();
      tick();
      bus.req = 2'b10;
      for (int k = 0; k < 7; k++) begin
         tick();
         compared++;
         if (bus.grant !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL busy_no_grant%0d: got %b expected 00", k, bus.grant);
         end
      end
      compared++;
      if (bus.done !== 1'b1 || bus.done_id !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL busy_first_done: got done=%b id=%b expected 1 0", bus.done, bus.done_id);
      end
      tick();
      compared++;
      if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL busy_idle_gap: got busy=%b grant=%b expected 0 00", bus.busy, bus.grant);
      end
      tick();
      compared++;
      if (bus.grant !== 2'b10) begin
         mismatched++;
         $display("[TB] FAIL busy_pending_grant: got %b expected 10", bus.grant);
      end
      bus.req = 2'b00;
      for (int k = 0; k < 10; k++) begin
         tick();
      end
      compared++;
      if (bus.done !== 1'b1 || bus.done_id !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL busy_pending_done: got done=%b id=%b expected 1 1", bus.done, bus.done_id);
      end
      tick();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_single();
      test_no_match();
      test_data_hold();
      test_abort_reset();
      test_back_to_back();
      test_busy_request();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
